// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load align/extend, regfile write port and instret.
// Define WB_FORWARD_EN to enable the write-value bypass outputs.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData,
  output logic [31:0] instret,
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e      state_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        write_q;
  logic [4:0]  wraddr_q;
  logic [31:0] wrdata_q;
  logic [31:0] instret_q;

  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  assign in_ready = (state_q == IDLE) & ~reset;
  assign accept   = in_valid & in_ready;

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (lo_q)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    // Unused funct3 encodings fall back to a full-word load
    case (f3_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      write_q   <= 1'b0;
      wraddr_q  <= 5'd0;
      wrdata_q  <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      write_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_is_load) begin
              state_q <= WAIT_LOAD;
              rd_q    <= in_rd;
              we_q    <= in_we;
              f3_q    <= in_funct3;
              lo_q    <= in_addr_lo;
            end else begin
              wrdata_q  <= in_result;
              wraddr_q  <= in_rd;
              write_q   <= in_we & (|in_rd);
              instret_q <= instret_q + 32'd1;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            wrdata_q  <= ld_data;
            wraddr_q  <= rd_q;
            write_q   <= we_q & (|rd_q);
            instret_q <= instret_q + 32'd1;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign write   = write_q;
  assign wrAddr  = wraddr_q;
  assign wrData  = wrdata_q;
  assign instret = instret_q;

`ifdef WB_FORWARD_EN
  // x0 never hits since write_q is already low for rd=0
  assign fwd_hit_a = write_q & (wraddr_q == fwd_rs1);
  assign fwd_hit_b = write_q & (wraddr_q == fwd_rs2);
  assign fwd_data  = wrdata_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs1, fwd_rs2};
  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with a reference model
// of retire order, load extension and forwarding.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_we, in_is_load;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write;
  logic [4:0]  wrAddr;
  logic [31:0] wrData, instret;
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_result(in_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .instret(instret),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;
  logic        fwd_fixed = 1'b0;
  logic [31:0] last_ir = 0;
  logic        cur_wr = 1'b0;
  logic [4:0]  cur_addr = 0;
  logic [31:0] cur_data = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] lo,
                                           logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic expect_retire(logic we, logic [4:0] rd, logic [31:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 32'd1;
    e.wr = we && (rd != 5'd0);
    e.rd = rd;
    e.data = d;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Called at a negedge, returns at a negedge after the retire edge.
  task automatic issue(logic ld, logic we, logic [4:0] rd, logic [2:0] f3,
                       logic [1:0] lo, logic [31:0] res, logic [31:0] mem,
                       int dly);
    in_valid = 1'b1;
    in_is_load = ld;
    in_we = we;
    in_rd = rd;
    in_funct3 = f3;
    in_addr_lo = lo;
    in_result = res;
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    if (!ld) expect_retire(we, rd, res);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dmem_rvalid = 1'b0;
    if (ld) begin
      for (int i = 0; i < dly; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_is_load = 1'($urandom_range(0, 1));
        in_we = 1'($urandom_range(0, 1));
        in_rd = 5'($urandom_range(0, 31));
        in_funct3 = 3'($urandom_range(0, 7));
        in_addr_lo = 2'($urandom_range(0, 3));
        in_result = $urandom;
        chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata = mem;
      chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
      expect_retire(we, rd, ref_load(f3, lo, mem));
      @(posedge clk);
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    fwd_rs1 = 5'd0;
    fwd_rs2 = 5'd0;
    forever begin
      @(posedge clk);
      #2;
      if (fwd_fixed) begin
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd3;
      end else begin
        fwd_rs1 = 5'($urandom_range(0, 7));
        fwd_rs2 = 5'($urandom_range(0, 7));
      end
    end
  end

  // Monitor: every instret step must match the oldest expected retire
  initial begin
    exp_t e;
    logic hit_a, hit_b;
    logic [31:0] fdat;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_ir = 0;
        cur_wr = 1'b0;
        cur_addr = 0;
        cur_data = 0;
      end else begin
        if (instret !== last_ir) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_retire: got instret %h want none at %0t",
                     instret, $time);
          end else begin
            e = sb.pop_front();
            chk("write", {31'd0, write}, {31'd0, e.wr});
            chk("wrAddr", {27'd0, wrAddr}, {27'd0, e.rd});
            chk("wrData", wrData, e.data);
            chk("instret", instret, e.cnt);
            cur_wr = e.wr;
            cur_addr = e.rd;
            cur_data = e.data;
          end
          last_ir = instret;
        end else begin
          cur_wr = 1'b0;
          chk("write_idle", {31'd0, write}, 32'd0);
          chk("wrAddr_hold", {27'd0, wrAddr}, {27'd0, cur_addr});
          chk("wrData_hold", wrData, cur_data);
        end
`ifdef WB_FORWARD_EN
        hit_a = cur_wr && (cur_addr == fwd_rs1);
        hit_b = cur_wr && (cur_addr == fwd_rs2);
        fdat = cur_data;
`else
        hit_a = 1'b0;
        hit_b = 1'b0;
        fdat = 32'd0;
`endif
        chk("fwd_hit_a", {31'd0, fwd_hit_a}, {31'd0, hit_a});
        chk("fwd_hit_b", {31'd0, fwd_hit_b}, {31'd0, hit_b});
        chk("fwd_data", fwd_data, fdat);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_we = 1'b0;
    in_rd = 5'd0;
    in_is_load = 1'b0;
    in_funct3 = 3'd0;
    in_addr_lo = 2'd0;
    in_result = 32'd0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    issue(1'b0, 1'b1, 5'd5, 3'd0, 2'd0, 32'h11, 32'd0, 0);
    issue(1'b0, 1'b1, 5'd6, 3'd0, 2'd0, 32'h22, 32'd0, 0);
    chk("b2b_instret", instret, 32'd2);
    chk("b2b_wrData", wrData, 32'h22);

    issue(1'b1, 1'b1, 5'd7, 3'b000, 2'd3, 32'd0, 32'h80AB_CDEF, 3);
    chk("lb_data", wrData, 32'hFFFF_FF80);
    chk("lb_write", {31'd0, write}, 32'd1);
    issue(1'b1, 1'b1, 5'd7, 3'b101, 2'd2, 32'd0, 32'h80AB_CDEF, 1);
    chk("lhu_data", wrData, 32'h0000_80AB);

    issue(1'b0, 1'b1, 5'd0, 3'd0, 2'd0, 32'hDEAD, 32'd0, 0);
    chk("x0_write", {31'd0, write}, 32'd0);
    chk("x0_instret", instret, 32'd5);

    fwd_fixed = 1'b1;
    issue(1'b0, 1'b1, 5'd9, 3'd0, 2'd0, 32'h99, 32'd0, 0);
`ifdef WB_FORWARD_EN
    chk("fwd9_hit_a", {31'd0, fwd_hit_a}, 32'd1);
    chk("fwd9_data", fwd_data, 32'h99);
`else
    chk("fwd9_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    chk("fwd9_data", fwd_data, 32'd0);
`endif
    chk("fwd9_hit_b", {31'd0, fwd_hit_b}, 32'd0);
    fwd_fixed = 1'b0;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      issue(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

    // Async reset mid-cycle with a load pending
    issue(1'b0, 1'b1, 5'd3, 3'd0, 2'd0, 32'h1234, 32'd0, 0);
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_we = 1'b1;
    in_rd = 5'd4;
    in_funct3 = 3'd2;
    @(posedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("arst_write", {31'd0, write}, 32'd0);
    chk("arst_wrAddr", {27'd0, wrAddr}, 32'd0);
    chk("arst_wrData", wrData, 32'd0);
    chk("arst_instret", instret, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("drop_write", {31'd0, write}, 32'd0);
    chk("drop_instret", instret, 32'd0);
    chk("drop_ready", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

    repeat (3) idle_cycle();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the Fast_RV32I core, sitting directly upstream of the register file. It accepts retiring instructions from the execute/memory stage and waits for the data-memory response on loads. It aligns and sign- or zero-extends load data, then drives the register file's single write port with a registered `write`/`wrAddr`/`wrData` triple. It also keeps a retired-instruction counter and can optionally bypass the value being written to operand readers.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: upstream offers an instruction.
- `in_ready` out 1: stage accepts; a transfer occurs on a rising edge with `in_valid & in_ready`.
- `in_we` in 1: instruction writes `rd`.
- `in_rd` in 5: destination register.
- `in_is_load` in 1: instruction is a load; data comes from `dmem_rdata`.
- `in_funct3` in 3: load type.
- `in_addr_lo` in 2: byte offset of the load address.
- `in_result` in 32: ALU/PC+4 result for non-loads.
- `dmem_rvalid` in 1: load data valid this cycle.
- `dmem_rdata` in 32: raw memory word.
- `write` out 1: register-file write enable.
- `wrAddr` out 5: register-file write address.
- `wrData` out 32: register-file write data.
- `instret` out 32: retired-instruction count.
- `fwd_rs1` in 5: forwarding query A (used only with `WB_FORWARD_EN`).
- `fwd_rs2` in 5: forwarding query B (used only with `WB_FORWARD_EN`).
- `fwd_hit_a` out 1: query A matches the pending write.
- `fwd_hit_b` out 1: query B matches the pending write.
- `fwd_data` out 32: bypass value (equals `wrData`).

## Operation
- State machine has two states:
  - IDLE: `in_ready` is 1.
  - WAIT_LOAD: `in_ready` is 0. Pending `rd`, `we`, `funct3` and `addr_lo` are held in capture registers.
- `in_ready` is `(state==IDLE) & ~reset`.
- Non-load accepted in IDLE:
  - On the same edge, `wrData` <= `in_result` and `wrAddr` <= `in_rd`.
  - `write` <= `in_we & (in_rd!=0)`.
  - A retire pulse is generated.
  - The state stays IDLE.
- Load accepted in IDLE:
  - The state moves to WAIT_LOAD and `write` <= 0.
  - Fields are captured from the inputs on that edge.
- In WAIT_LOAD, on an edge with `dmem_rvalid`=1:
  - `wrData` <= aligned data and `wrAddr` <= captured rd.
  - `write` <= `captured_we & (rd!=0)`.
  - A retire pulse is generated and the state returns to IDLE.
  - Without `dmem_rvalid`, the stage holds and `write` <= 0.
- Load alignment:
  - Byte selection uses `addr_lo`; halfword selection uses `addr_lo[1]`, and `addr_lo[0]` is ignored.
  - 000 (LB): sign-extend the byte.
  - 001 (LH): sign-extend the halfword.
  - 010 (LW): full word; `addr_lo` is ignored.
  - 100 (LBU): zero-extend the byte.
  - 101 (LHU): zero-extend the halfword.
  - 011, 110 and 111 are treated as LW.
- With no transfer and no response, `write` <= 0 each edge. `wrAddr` and `wrData` hold their last values.
- `dmem_rvalid` in IDLE is ignored.
- `instret` increments by 1 on each retire pulse, including `we`=0 and rd=0 cases, and wraps from 0xFFFFFFFF to 0.
- Reset, asynchronous and legal mid-operation:
  - State returns to IDLE.
  - `write`=0, `wrAddr`=0, `wrData`=0, `instret`=0.
  - `in_ready`=0 while `reset` is high.
  - A pending load is discarded, and a later `dmem_rvalid` is ignored.

## Timing
- Non-load accepted at edge N: `write` is high during cycle N+1 (latency 1). Throughput is one instruction per cycle, so back-to-back non-loads give consecutive `write` pulses.
- Load accepted at edge N: `in_ready`=0 from cycle N+1. If `dmem_rvalid` is sampled at edge M ≥ N+1, `write` is high in cycle M+1 and `in_ready`=1 in cycle M+1. A new instruction can be accepted at edge M+1.
- `instret` updates on the same edge as the registered `write`.
- Forward outputs are combinational from the current output registers.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_hit_a` = `write & (wrAddr==fwd_rs1)`.
  - `fwd_hit_b` = `write & (wrAddr==fwd_rs2)`.
  - `fwd_data` = `wrData`.
  - This covers the cycle in which the register file has not yet absorbed the write.
  - Hits are never asserted for x0, because `write` is already 0 for rd=0.
- `WB_FORWARD_EN` undefined: `fwd_hit_a`=0, `fwd_hit_b`=0, `fwd_data`=0; `fwd_rs1`/`fwd_rs2` are ignored.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> `write`=0, `wrAddr`=0, `wrData`=0, `instret`=0, `in_ready`=0 immediately. After release, `in_ready`=1.
- Two back-to-back non-loads, rd=5 `in_result`=0x11 then rd=6 `in_result`=0x22 -> `write` high two consecutive cycles with (5,0x11) then (6,0x22); `instret`=2.
- LB with `addr_lo`=3, rd=7, and `dmem_rvalid` 3 cycles later with `dmem_rdata`=0x80AB_CDEF:
  - `in_ready`=0 while waiting.
  - `write` one cycle after the response with `wrData`=0xFFFF_FF80.
  - LHU at `addr_lo`=2 with the same word -> 0x0000_80AB.
- Non-load to rd=0 with `in_we`=1 -> `write` stays 0; `instret` still increments.
- Load pending and `reset` pulsed before `dmem_rvalid` -> no write after a later `dmem_rvalid`; state IDLE.
- With `WB_FORWARD_EN`: `write` to rd=9 and `fwd_rs1`=9, `fwd_rs2`=3 -> `fwd_hit_a`=1, `fwd_hit_b`=0, `fwd_data`=`wrData`. Without `WB_FORWARD_EN` -> all forward outputs 0.
